// File: rtl/btb_pkg.sv
// Shared types, geometry and helper functions for the branch target buffer.
package btb_pkg;

  localparam int BIT_ENTRY = 3;
  localparam int ADDR_W    = 32;
  localparam int N_ENTRY   = 1 << BIT_ENTRY;
  localparam int TAG_W     = ADDR_W - BIT_ENTRY - 2;

  typedef logic [BIT_ENTRY-1:0] idx_t;
  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [ADDR_W-1:0]    addr_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } btb_meta_t;

  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_STRONG_N = 2'b00;
  localparam ctr_t CTR_WEAK_T   = 2'b10;
  localparam ctr_t CTR_STRONG_T = 2'b11;

  function automatic idx_t btb_index(input addr_t pc);
    return pc[BIT_ENTRY+1:2];
  endfunction

  function automatic tag_t btb_tag(input addr_t pc);
    return pc[ADDR_W-1:BIT_ENTRY+2];
  endfunction

  // Two-bit saturating counter step towards the resolved direction.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    if (taken) nxt = (ctr == CTR_STRONG_T) ? ctr : ctr + 2'd1;
    else       nxt = (ctr == CTR_STRONG_N) ? ctr : ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/btb_array.sv
// Small register-file storage: one combinational read port with write
// forwarding, one write port that also exposes the current entry for RMW.
module btb_array #(
  parameter int W         = 8,
  parameter int BIT_ENTRY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_ENTRY-1:0] r_index,
  output logic [W-1:0]         r_dout,
  input  logic                 load,
  input  logic [BIT_ENTRY-1:0] w_index,
  input  logic [W-1:0]         w_din,
  output logic [W-1:0]         w_dout
);

  localparam int N = 1 << BIT_ENTRY;

  logic [W-1:0] mem_q [N];
  logic [W-1:0] mem_d [N];

  // Next storage contents: only the addressed entry changes on a load.
  always_comb begin
    mem_d = mem_q;
    if (load) mem_d[w_index] = w_din;
  end

  // Storage register, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports; a write in flight to the read index is visible immediately.
  always_comb begin
    r_dout = (load && (r_index == w_index)) ? w_din : mem_q[r_index];
    w_dout = mem_q[w_index];
  end

endmodule

// File: rtl/btb_predictor.sv
// Fetch-side BTB: same-cycle lookup, two-stage resolved-branch update,
// and wrapping performance counters.
module btb_predictor
  import btb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_stall,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic              ex_mispredict,
  output logic [31:0]       cnt_lookup,
  output logic [31:0]       cnt_hit,
  output logic [31:0]       cnt_mispred
);

  localparam int META_W = $bits(btb_meta_t);

  // Update stage register (S1) and perf counters.
  logic        upd_v_q, upd_v_d;
  addr_t       upd_pc_q, upd_pc_d;
  logic        upd_taken_q, upd_taken_d;
  addr_t       upd_target_q, upd_target_d;
  logic [31:0] cnt_lookup_q, cnt_lookup_d;
  logic [31:0] cnt_hit_q, cnt_hit_d;
  logic [31:0] cnt_mispred_q, cnt_mispred_d;

  // Array interface.
  idx_t              r_idx, w_idx;
  logic [META_W-1:0] meta_r_raw, meta_w_raw, meta_din;
  addr_t             tgt_r, tgt_w, tgt_din;
  ctr_t              ctr_r, ctr_w, ctr_din;
  btb_meta_t         meta_r, meta_w, meta_new;
  logic              load;

  assign r_idx      = btb_index(if_pc);
  assign w_idx      = btb_index(upd_pc_q);
  assign meta_r     = btb_meta_t'(meta_r_raw);
  assign meta_w     = btb_meta_t'(meta_w_raw);
  assign meta_din   = META_W'(meta_new);

  btb_array #(.W(META_W), .BIT_ENTRY(BIT_ENTRY)) u_meta (
    .clk(clk), .rst(rst), .r_index(r_idx), .r_dout(meta_r_raw),
    .load(load), .w_index(w_idx), .w_din(meta_din), .w_dout(meta_w_raw)
  );

  btb_array #(.W(ADDR_W), .BIT_ENTRY(BIT_ENTRY)) u_target (
    .clk(clk), .rst(rst), .r_index(r_idx), .r_dout(tgt_r),
    .load(load), .w_index(w_idx), .w_din(tgt_din), .w_dout(tgt_w)
  );

  btb_array #(.W(2), .BIT_ENTRY(BIT_ENTRY)) u_ctr (
    .clk(clk), .rst(rst), .r_index(r_idx), .r_dout(ctr_r),
    .load(load), .w_index(w_idx), .w_din(ctr_din), .w_dout(ctr_w)
  );

  // Lookup: tag compare and prediction for the fetch PC.
  always_comb begin
    pred_hit    = meta_r.valid && (meta_r.tag == btb_tag(if_pc));
    pred_taken  = pred_hit && ctr_r[1];
    pred_target = pred_taken ? tgt_r : if_pc + 32'd4;
  end

  // Resolved-branch mispredict, consumed directly by the redirect logic.
  always_comb begin
    ex_mispredict = ex_valid &&
                    ((ex_taken != ex_pred_taken) ||
                     (ex_taken && (ex_target != ex_pred_target)));
  end

  // S2 read-modify-write: train a hitting entry, allocate on a taken miss.
  always_comb begin
    load     = 1'b0;
    meta_new = meta_w;
    tgt_din  = tgt_w;
    ctr_din  = ctr_w;
    if (upd_v_q) begin
      if (meta_w.valid && (meta_w.tag == btb_tag(upd_pc_q))) begin
        load    = 1'b1;
        ctr_din = ctr_next(ctr_w, upd_taken_q);
        if (upd_taken_q) tgt_din = upd_target_q;
      end else if (upd_taken_q) begin
        load           = 1'b1;
        meta_new.valid = 1'b1;
        meta_new.tag   = btb_tag(upd_pc_q);
        tgt_din        = upd_target_q;
        ctr_din        = CTR_WEAK_T;
      end
    end
  end

  // S1 capture and counter next-state.
  always_comb begin
    upd_v_d      = ex_valid;
    upd_pc_d     = upd_pc_q;
    upd_taken_d  = upd_taken_q;
    upd_target_d = upd_target_q;
    if (ex_valid) begin
      upd_pc_d     = ex_pc;
      upd_taken_d  = ex_taken;
      upd_target_d = ex_target;
    end
    cnt_lookup_d  = cnt_lookup_q + {31'd0, ~if_stall};
    cnt_hit_d     = cnt_hit_q + {31'd0, pred_hit & ~if_stall};
    cnt_mispred_d = cnt_mispred_q + {31'd0, ex_mispredict};
  end

  // Update register and counters; reset drops any pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_v_q       <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      upd_target_q  <= '0;
      cnt_lookup_q  <= '0;
      cnt_hit_q     <= '0;
      cnt_mispred_q <= '0;
    end else begin
      upd_v_q       <= upd_v_d;
      upd_pc_q      <= upd_pc_d;
      upd_taken_q   <= upd_taken_d;
      upd_target_q  <= upd_target_d;
      cnt_lookup_q  <= cnt_lookup_d;
      cnt_hit_q     <= cnt_hit_d;
      cnt_mispred_q <= cnt_mispred_d;
    end
  end

  assign cnt_lookup  = cnt_lookup_q;
  assign cnt_hit     = cnt_hit_q;
  assign cnt_mispred = cnt_mispred_q;

endmodule
